hop_cnt_out_alloc: RTL and testbench
====================================

// Module: hop_cnt_out_alloc
// PURPOSE
//  Output-port allocator and switch-traversal controller for one mesh router output. Sits directly
//  downstream of hop_cnt_arbiter: takes its winner/tie result, resolves ties by round-robin, locks
//  the grant for a whole wormhole packet (HEAD..TAIL), and moves flits from the granted input
//  buffer to the output link with a valid/ready handshake.
// PARAMETERS
//  IN_N      5  number of router inputs competing for this output
//  FLIT_W    8  flit payload width in bits (type carried separately)
// PORTS
//  clk_i               in   1                 clock
//  rst_ni              in   1                 asynchronous active-low reset
//  hc_arb_res_i        in   $clog2(IN_N)      hop_cnt_arbiter winner index
//  hc_vld_i            in   IN_N              hop_cnt_arbiter vld_input_o (inputs tied at max hop count)
//  hc_not_conclusive_i in   1                 hop_cnt_arbiter tie flag
//  in_vld_i            in   IN_N              input buffer i non-empty and routed to this output
//  in_type_i           in   IN_N*2            flit type per input: 00 BODY, 01 HEAD, 10 TAIL, 11 HEAD_TAIL
//  in_data_i           in   IN_N*FLIT_W       front flit per input, input i at bits [i*FLIT_W +: FLIT_W]
//  in_rd_o             out  IN_N              one-hot pop strobe to the granted input buffer
//  out_rdy_i           in   1                 downstream link/buffer can accept a flit
//  out_wr_o            out  1                 flit transferred on out_data_o this cycle
//  out_data_o          out  FLIT_W            muxed flit from the granted input
//  out_type_o          out  2                 muxed flit type from the granted input
//  grant_o             out  IN_N              one-hot registered grant, 0 when idle
//  grant_idx_o         out  $clog2(IN_N)      encoded grant index, 0 when idle
//  busy_o              out  1                 1 while in LOCKED
// BEHAVIOUR
//  - Reset, async, any state: state=IDLE, grant_o=0, grant_idx_o=0, rr_ptr=0, busy_o=0.
//    in_rd_o=0, out_wr_o=0 since they are combinational from the grant. A packet in flight is dropped.
//  - FSM IDLE:
//    - If hc_not_conclusive_i=0 and hc_vld_i[hc_arb_res_i]=1, winner = hc_arb_res_i.
//    - If hc_not_conclusive_i=1, winner = first set bit of hc_vld_i, searching rr_ptr, rr_ptr+1, ...
//      and wrapping modulo IN_N.
//    - If neither case applies (including hc_vld_i=0), no grant; stay in IDLE.
//    - On a winner: register grant_o/grant_idx_o and go to LOCKED. Grant is visible the next
//      cycle, so there is 1-cycle allocation latency. No flit moves in IDLE.
//  - FSM LOCKED, grant g:
//    - xfer = in_vld_i[g] & out_rdy_i. Combinationally: out_wr_o=xfer, in_rd_o[g]=xfer,
//      out_data_o/out_type_o = input g.
//    - Hop-arbiter inputs are ignored while LOCKED.
//    - xfer with type TAIL or HEAD_TAIL: next state IDLE, grant cleared next cycle,
//      rr_ptr <= (g==IN_N-1) ? 0 : g+1.
//    - xfer with HEAD or BODY: stay LOCKED.
//    - No xfer: hold all state. in_vld_i[g] dropping mid-packet is a stall, not a release.
//  - rr_ptr advances only on packet release, never on an allocation that has no tie.
//  - out_data_o/out_type_o are don't-care when out_wr_o=0 (bench must not check them);
//    implementation drives 0 in IDLE.
//  - Back-to-back packets: a 1-cycle bubble (IDLE) between a TAIL transfer and the next grant.
//  - A HEAD_TAIL packet costs 2 cycles minimum: allocate, then transfer.
//  - Protocol violations (a HEAD seen mid-packet) are not detected. The flit is forwarded as data.
// TESTING
//  - Conclusive win: hc_arb_res=2, hc_vld=00100, ncl=0, in 2 sends HEAD,BODY,TAIL, out_rdy=1.
//    -> grant_o=00100 at cycle 1; out_wr on cycles 1-3; grant_o=0 at cycle 4.
//  - Tie RR: rr_ptr=0, hc_vld=10010, ncl=1 for two packets.
//    -> first grant idx 1, rr_ptr=2, second grant idx 4, rr_ptr wraps to 0.
//  - Backpressure: locked on input 3, out_rdy=0 for 4 cycles mid-packet.
//    -> out_wr=0, in_rd=0, grant holds; resumes on out_rdy=1 with no flit lost or duplicated.
//  - HEAD_TAIL: single-flit packet on input 0.
//    -> exactly one out_wr, busy_o high for 1 cycle, then IDLE.
//  - No request: hc_vld=0 with ncl=1 (hop arbiter all-zero case).
//    -> stays IDLE, grant_o=0, no in_rd.
//  - Async reset mid-packet: rst_ni low after the BODY flit.
//    -> grant_o=0, busy_o=0 immediately; after release, a fresh allocation starts from rr_ptr=0.

Source files
------------

// File: rtl/hop_cnt_out_alloc.sv
// Output-port allocator for one mesh router output: resolves hop-count ties round-robin,
// locks the grant for a whole wormhole packet and moves flits with a valid/ready handshake.
//
// state  | meaning
// IDLE   | no grant held; allocating from hop-arbiter result
// LOCKED | grant held on one input until its TAIL/HEAD_TAIL flit transfers
module hop_cnt_out_alloc #(
  parameter int IN_N   = 5,
  parameter int FLIT_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [$clog2(IN_N)-1:0]   hc_arb_res_i,
  input  logic [IN_N-1:0]           hc_vld_i,
  input  logic                      hc_not_conclusive_i,
  input  logic [IN_N-1:0]           in_vld_i,
  input  logic [IN_N*2-1:0]         in_type_i,
  input  logic [IN_N*FLIT_W-1:0]    in_data_i,
  output logic [IN_N-1:0]           in_rd_o,
  input  logic                      out_rdy_i,
  output logic                      out_wr_o,
  output logic [FLIT_W-1:0]         out_data_o,
  output logic [1:0]                out_type_o,
  output logic [IN_N-1:0]           grant_o,
  output logic [$clog2(IN_N)-1:0]   grant_idx_o,
  output logic                      busy_o
);

  localparam int IDX_W = $clog2(IN_N);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t             state, state_nxt;
  logic [IN_N-1:0]    grant_nxt;
  logic [IDX_W-1:0]   grant_idx_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               xfer;
  logic [1:0]         sel_type;
  logic [FLIT_W-1:0]  sel_data;

  logic [1:0]         type_arr [IN_N];
  logic [FLIT_W-1:0]  data_arr [IN_N];

  always_comb begin
    for (int i = 0; i < IN_N; i++) begin
      type_arr[i] = in_type_i[i*2 +: 2];
      data_arr[i] = in_data_i[i*FLIT_W +: FLIT_W];
    end
  end

  // Winner selection: trust the hop arbiter unless it reports a tie, then rotate from rr_ptr.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    if (!hc_not_conclusive_i) begin
      if (int'(hc_arb_res_i) < IN_N && hc_vld_i[hc_arb_res_i]) begin
        win_found = 1'b1;
        win_idx   = hc_arb_res_i;
      end
    end else begin
      for (int k = 0; k < IN_N; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= IN_N) idx = idx - IN_N;
        if (!win_found && hc_vld_i[idx]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(idx);
        end
      end
    end
  end

  always_comb begin
    sel_type = type_arr[grant_idx_o];
    sel_data = data_arr[grant_idx_o];
    busy_o   = (state == LOCKED);
    xfer     = busy_o && in_vld_i[grant_idx_o] && out_rdy_i;
    out_wr_o = xfer;
    in_rd_o  = xfer ? grant_o : '0;
    out_data_o = busy_o ? sel_data : '0;
    out_type_o = busy_o ? sel_type : '0;
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_o;
    grant_idx_nxt = grant_idx_o;
    rr_ptr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt     = LOCKED;
          grant_idx_nxt = win_idx;
          for (int i = 0; i < IN_N; i++) grant_nxt[i] = (i == int'(win_idx));
        end
      end
      LOCKED: begin
        // type[1] set means TAIL or HEAD_TAIL: packet ends with this flit
        if (xfer && sel_type[1]) begin
          state_nxt     = IDLE;
          grant_nxt     = '0;
          grant_idx_nxt = '0;
          rr_ptr_nxt    = (grant_idx_o == IDX_W'(IN_N-1)) ? '0 : grant_idx_o + 1'b1;
        end
      end
      default: begin
        state_nxt     = IDLE;
        grant_nxt     = '0;
        grant_idx_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      grant_o     <= '0;
      grant_idx_o <= '0;
      rr_ptr      <= '0;
    end else begin
      state       <= state_nxt;
      grant_o     <= grant_nxt;
      grant_idx_o <= grant_idx_nxt;
      rr_ptr      <= rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_hop_cnt_out_alloc.sv
// Directed bench for hop_cnt_out_alloc: conclusive win, round-robin ties, backpressure,
// single-flit packets, idle with no request, and async reset mid-packet.
module tb_hop_cnt_out_alloc;

  localparam int IN_N   = 5;
  localparam int FLIT_W = 8;
  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [2:0]             hc_arb_res;
  logic [IN_N-1:0]        hc_vld;
  logic                   hc_ncl;
  logic [IN_N-1:0]        in_vld;
  logic [IN_N*2-1:0]      in_type;
  logic [IN_N*FLIT_W-1:0] in_data;
  logic [IN_N-1:0]        in_rd;
  logic                   out_rdy;
  logic                   out_wr;
  logic [FLIT_W-1:0]      out_data;
  logic [1:0]             out_type;
  logic [IN_N-1:0]        grant;
  logic [2:0]             grant_idx;
  logic                   busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hop_cnt_out_alloc #(.IN_N(IN_N), .FLIT_W(FLIT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .hc_arb_res_i(hc_arb_res), .hc_vld_i(hc_vld), .hc_not_conclusive_i(hc_ncl),
    .in_vld_i(in_vld), .in_type_i(in_type), .in_data_i(in_data), .in_rd_o(in_rd),
    .out_rdy_i(out_rdy), .out_wr_o(out_wr), .out_data_o(out_data), .out_type_o(out_type),
    .grant_o(grant), .grant_idx_o(grant_idx), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one front flit on input i only.
  task automatic flit(input int i, input logic [1:0] t, input logic [7:0] d);
    in_vld = '0;
    in_vld[i] = 1'b1;
    in_type[i*2 +: 2] = t;
    in_data[i*FLIT_W +: FLIT_W] = d;
  endtask

  initial begin
    rst_n = 1'b0; hc_arb_res = '0; hc_vld = '0; hc_ncl = 1'b0;
    in_vld = '0; in_type = '0; in_data = '0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_idx", 32'(grant_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr", 32'(out_wr), 0);
    rst_n = 1'b1;

    // conclusive win on input 2, HEAD/BODY/TAIL
    step();
    hc_arb_res = 3'd2; hc_vld = 5'b00100; hc_ncl = 1'b0; out_rdy = 1'b1;
    flit(2, T_HEAD, 8'hA1);
    #1;
    chk("c_idle_grant", 32'(grant), 0);
    chk("c_idle_wr", 32'(out_wr), 0);
    chk("c_idle_rd", 32'(in_rd), 0);
    step(); hc_vld = '0; #1;
    chk("c_grant", 32'(grant), 32'b00100);
    chk("c_idx", 32'(grant_idx), 2);
    chk("c_busy", 32'(busy), 1);
    chk("c_wr1", 32'(out_wr), 1);
    chk("c_rd1", 32'(in_rd), 32'b00100);
    chk("c_data1", 32'(out_data), 32'hA1);
    chk("c_type1", 32'(out_type), 32'(T_HEAD));
    step(); flit(2, T_BODY, 8'hA2); #1;
    chk("c_wr2", 32'(out_wr), 1);
    chk("c_data2", 32'(out_data), 32'hA2);
    step(); flit(2, T_TAIL, 8'hA3); #1;
    chk("c_wr3", 32'(out_wr), 1);
    chk("c_data3", 32'(out_data), 32'hA3);
    chk("c_type3", 32'(out_type), 32'(T_TAIL));
    step(); in_vld = '0; #1;
    chk("c_rel_grant", 32'(grant), 0);
    chk("c_rel_busy", 32'(busy), 0);
    chk("c_rel_wr", 32'(out_wr), 0);

    // round-robin ties from rr_ptr=0
    rst_n = 1'b0; #1; rst_n = 1'b1;
    hc_vld = 5'b10010; hc_ncl = 1'b1; hc_arb_res = 3'd0;
    flit(1, T_HT, 8'hB1);
    #1;
    chk("rr_idle_wr", 32'(out_wr), 0);
    step(); #1;
    chk("rr_grant1", 32'(grant), 32'b00010);
    chk("rr_idx1", 32'(grant_idx), 1);
    chk("rr_wr1", 32'(out_wr), 1);
    chk("rr_data1", 32'(out_data), 32'hB1);
    step(); flit(4, T_HT, 8'hC1); #1;
    chk("rr_bubble1", 32'(grant), 0);
    chk("rr_bubble_wr", 32'(out_wr), 0);
    step(); #1;
    chk("rr_idx2", 32'(grant_idx), 4);
    chk("rr_rd2", 32'(in_rd), 32'b10000);
    chk("rr_data2", 32'(out_data), 32'hC1);
    step(); flit(1, T_HT, 8'hB2); #1;
    chk("rr_bubble2", 32'(grant), 0);
    step(); #1;
    chk("rr_wrap_idx", 32'(grant_idx), 1);
    chk("rr_wrap_wr", 32'(out_wr), 1);
    step(); hc_vld = '0; hc_ncl = 1'b0; in_vld = '0; #1;
    chk("rr_end_grant", 32'(grant), 0);

    // backpressure and input stall on input 3
    hc_arb_res = 3'd3; hc_vld = 5'b01000;
    flit(3, T_HEAD, 8'h31);
    step(); hc_vld = '0; #1;
    chk("bp_grant", 32'(grant), 32'b01000);
    chk("bp_wr_head", 32'(out_wr), 1);
    chk("bp_data_head", 32'(out_data), 32'h31);
    step(); flit(3, T_BODY, 8'h32); out_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_stall_wr", 32'(out_wr), 0);
      chk("bp_stall_rd", 32'(in_rd), 0);
      chk("bp_stall_grant", 32'(grant), 32'b01000);
      step();
    end
    out_rdy = 1'b1; #1;
    chk("bp_resume_wr", 32'(out_wr), 1);
    chk("bp_resume_rd", 32'(in_rd), 32'b01000);
    chk("bp_resume_data", 32'(out_data), 32'h32);
    chk("bp_resume_type", 32'(out_type), 32'(T_BODY));
    step(); in_vld = '0; #1;
    chk("bp_empty_wr", 32'(out_wr), 0);
    chk("bp_empty_grant", 32'(grant), 32'b01000);
    step(); flit(3, T_TAIL, 8'h33); #1;
    chk("bp_tail_wr", 32'(out_wr), 1);
    chk("bp_tail_data", 32'(out_data), 32'h33);
    step(); in_vld = '0; #1;
    chk("bp_rel_grant", 32'(grant), 0);
    chk("bp_rel_busy", 32'(busy), 0);

    // single-flit packet on input 0
    hc_arb_res = 3'd0; hc_vld = 5'b00001;
    flit(0, T_HT, 8'hD1);
    #1;
    chk("ht_idle_busy", 32'(busy), 0);
    step(); hc_vld = '0; #1;
    chk("ht_busy", 32'(busy), 1);
    chk("ht_wr", 32'(out_wr), 1);
    chk("ht_rd", 32'(in_rd), 32'b00001);
    chk("ht_data", 32'(out_data), 32'hD1);
    step(); in_vld = '0; #1;
    chk("ht_rel_busy", 32'(busy), 0);
    chk("ht_rel_grant", 32'(grant), 0);
    chk("ht_rel_wr", 32'(out_wr), 0);

    // no request: tie flag with empty hc_vld
    hc_vld = '0; hc_ncl = 1'b1; in_vld = 5'b11111; in_type = {5{T_HEAD}};
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      chk("nr_grant", 32'(grant), 0);
      chk("nr_rd", 32'(in_rd), 0);
      chk("nr_busy", 32'(busy), 0);
    end

    // async reset mid-packet, then fresh tie resolution from rr_ptr=0
    hc_ncl = 1'b0; hc_arb_res = 3'd2; hc_vld = 5'b00100;
    flit(2, T_HEAD, 8'hE1);
    step(); hc_vld = '0; #1;
    chk("ar_grant", 32'(grant), 32'b00100);
    step(); flit(2, T_BODY, 8'hE2); #1;
    chk("ar_body_wr", 32'(out_wr), 1);
    chk("ar_body_data", 32'(out_data), 32'hE2);
    step(); flit(2, T_BODY, 8'hE3); #1;
    chk("ar_pre_busy", 32'(busy), 1);
    rst_n = 1'b0; #1;
    chk("ar_grant0", 32'(grant), 0);
    chk("ar_busy0", 32'(busy), 0);
    chk("ar_wr0", 32'(out_wr), 0);
    chk("ar_rd0", 32'(in_rd), 0);
    #1 rst_n = 1'b1;
    in_vld = '0; hc_vld = 5'b10101; hc_ncl = 1'b1;
    step(); #1;
    chk("ar_fresh_idx", 32'(grant_idx), 0);
    chk("ar_fresh_grant", 32'(grant), 32'b00001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
